// File: rtl/encoder_layer_1_attention_self_value_weight_sink.sv
// Runtime-loaded sink for layer-1 self-attention value weights: streams beats into a
// DEPTH-word RAM and serves them through the same 2-cycle ce0-gated read port as the weight ROMs.
module encoder_layer_1_attention_self_value_weight_sink #(
  parameter int VALUE_WEIGHT_TENSOR_SIZE_DIM_0 = 32,
  parameter int VALUE_WEIGHT_PRECISION_0       = 16,
  parameter int VALUE_WEIGHT_PRECISION_1       = 3,
  parameter int VALUE_WEIGHT_PARALLELISM_DIM_0 = 1,
  parameter int VALUE_WEIGHT_PARALLELISM_DIM_1 = 1,
  localparam int P          = VALUE_WEIGHT_PARALLELISM_DIM_0 * VALUE_WEIGHT_PARALLELISM_DIM_1,
  localparam int DEPTH      = VALUE_WEIGHT_TENSOR_SIZE_DIM_0 / VALUE_WEIGHT_PARALLELISM_DIM_0,
  localparam int ADDR_WIDTH = $clog2(DEPTH) + 1,
  localparam int WORD_W     = VALUE_WEIGHT_PRECISION_0 * P
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [VALUE_WEIGHT_PRECISION_0-1:0] data_in [P],
  input  logic                                data_in_valid,
  output logic                                data_in_ready,
  input  logic                                clear,
  output logic                                loaded,
  output logic [ADDR_WIDTH-1:0]               fill_count,
  output logic                                overrun,
  input  logic [ADDR_WIDTH-1:0]               address0,
  input  logic                                ce0,
  output logic [WORD_W-1:0]                   q0,
  output logic                                dbg_state
);

  // Handshake: a beat transfers on a rising clk edge where data_in_valid && data_in_ready;
  // data_in_ready depends on registered state only, never on data_in_valid.

  typedef enum logic {ST_LOAD = 1'b0, ST_FULL = 1'b1} state_e;

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   wptr_q;
  logic [ADDR_WIDTH-1:0]   fill_q;
  logic                    overrun_q;
  logic [WORD_W-1:0]       t0_q;
  logic [WORD_W-1:0]       q0_q;
  logic [WORD_W-1:0]       wdata;
  logic                    wr_en;
  logic [WORD_W-1:0]       ram [DEPTH];

  always_comb begin
    wdata = '0;
    for (int j = 0; j < P; j++) begin
      wdata[VALUE_WEIGHT_PRECISION_0*j +: VALUE_WEIGHT_PRECISION_0] = data_in[j];
    end
  end

  assign data_in_ready = (state_q == ST_LOAD);
  assign loaded        = (state_q == ST_FULL);
  assign fill_count    = fill_q;
  assign overrun       = overrun_q;
  assign q0            = q0_q;
  assign dbg_state     = state_q;

  // clear (and reset) override a coincident handshake, so the beat never reaches the RAM.
  assign wr_en = rst_n && !clear && (state_q == ST_LOAD) && data_in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      wptr_q    <= '0;
      fill_q    <= '0;
      overrun_q <= 1'b0;
    end else if (clear) begin
      state_q   <= ST_LOAD;
      wptr_q    <= '0;
      fill_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (data_in_valid) begin
            fill_q <= fill_q + 1'b1;
            if (wptr_q == LAST_A) begin
              wptr_q  <= '0;
              state_q <= ST_FULL;
            end else begin
              wptr_q <= wptr_q + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (data_in_valid) overrun_q <= 1'b1;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wptr_q[IDX_W-1:0]] <= wdata;
  end

  // Nonblocking RAM update gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t0_q <= '0;
      q0_q <= '0;
    end else if (ce0) begin
      t0_q <= (address0 < DEPTH_A) ? ram[address0[IDX_W-1:0]] : '0;
      q0_q <= t0_q;
    end
  end

endmodule
